spi_flash_dma: RTL and testbench

Second-generation SPI NOR flash reader with DMA, successor to the fixed-function flash block. It sits on the peripheral register bus with a 4-bit register window. It streams flash contents into system memory through the DMA write port. Over the first generation it adds:
- a programmable SCK divider;
- fast-read (0x0B + dummy byte) mode;
- power-down and wake commands;
- software abort;
- a busy flag and a maskable interrupt.

---
 rtl/spi_flash_pkg.sv | 47 ++++
 rtl/spi_shift_engine.sv | 87 ++++++++
 rtl/spi_flash_dma.sv | 198 +++++++++++++++++++
 tb/tb_spi_flash_dma.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI NOR flash DMA reader: state and opcode
// encodings, register offsets and register bit positions.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_MEM_WR, S_DONE
  } state_e;

  typedef enum logic [1:0] {OP_READ, OP_FAST, OP_WAKE, OP_SLEEP} op_e;

  localparam logic [7:0] OPC_READ  = 8'h03;
  localparam logic [7:0] OPC_FAST  = 8'h0B;
  localparam logic [7:0] OPC_WAKE  = 8'hAB;
  localparam logic [7:0] OPC_SLEEP = 8'hB9;

  localparam int REG_ADDR_LO   = 0;
  localparam int REG_ADDR_HI   = 1;
  localparam int REG_CMD       = 2;
  localparam int REG_DATA      = 3;
  localparam int REG_STATUS    = 4;
  localparam int REG_DMA_ADDR  = 5;
  localparam int REG_DMA_COUNT = 6;
  localparam int REG_CTRL      = 7;

  localparam int CMD_READ  = 0;
  localparam int CMD_WAKE  = 1;
  localparam int CMD_SLEEP = 2;
  localparam int CMD_ABORT = 3;

  localparam int ST_DONE    = 0;
  localparam int ST_BUSY    = 1;
  localparam int ST_ABORTED = 2;

  localparam int CTRL_FAST    = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_DIV_LSB = 4;

  function automatic logic [7:0] opcode(op_e op);
    case (op)
      OP_FAST:  return OPC_FAST;
      OP_WAKE:  return OPC_WAKE;
      OP_SLEEP: return OPC_SLEEP;
      default:  return OPC_READ;
    endcase
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// Mode-0 SPI bit engine: SCK divider plus an MSB-first shifter of up to 24
// bits. done fires combinationally on the final SCK fall so a follow-on
// segment can start on the same edge without an SCK gap.
module spi_shift_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        mosi_en,
  input  logic [3:0]  div,
  input  logic [4:0]  nbits,
  input  logic [23:0] tx_data,
  input  logic        miso,
  output logic        sck,
  output logic        mosi,
  output logic        done,
  output logic [15:0] rx_data
);
  logic        active_q, active_d, sck_q, sck_d, men_q, men_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  bits_q, bits_d;
  logic [23:0] sh_q, sh_d;
  logic [15:0] rx_q, rx_d;
  logic        tick, rise, fall;

  always_comb begin
    tick     = active_q && (cnt_q == div);
    rise     = tick && !sck_q;
    fall     = tick && sck_q;
    done     = fall && (bits_q == 5'd1);
    active_d = active_q;
    sck_d    = sck_q;
    men_d    = men_q;
    cnt_d    = cnt_q;
    bits_d   = bits_q;
    sh_d     = sh_q;
    rx_d     = rx_q;
    if (active_q) begin
      cnt_d = tick ? 4'd0 : cnt_q + 4'd1;
      if (tick) sck_d = ~sck_q;
      if (rise) rx_d = {rx_q[14:0], miso};
      if (fall) begin
        sh_d   = {sh_q[22:0], 1'b0};
        bits_d = bits_q - 5'd1;
        if (done) active_d = 1'b0;
      end
    end
    if (stop) begin
      active_d = 1'b0;
      sck_d    = 1'b0;
      cnt_d    = 4'd0;
    end
    if (start) begin
      active_d = 1'b1;
      sck_d    = 1'b0;
      cnt_d    = 4'd0;
      bits_d   = nbits;
      sh_d     = tx_data;
      men_d    = mosi_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      men_q    <= 1'b0;
      cnt_q    <= 4'd0;
      bits_q   <= 5'd0;
      sh_q     <= 24'd0;
      rx_q     <= 16'd0;
    end else begin
      active_q <= active_d;
      sck_q    <= sck_d;
      men_q    <= men_d;
      cnt_q    <= cnt_d;
      bits_q   <= bits_d;
      sh_q     <= sh_d;
      rx_q     <= rx_d;
    end
  end

  assign sck     = sck_q;
  assign mosi    = men_q & sh_q[23];
  assign rx_data = rx_q;

endmodule

// File: rtl/spi_flash_dma.sv
// SPI NOR flash reader that streams flash words into memory over a DMA write
// port; register file, command sequencer and DMA handshake live here.
module spi_flash_dma
  import spi_flash_pkg::*;
#(
  parameter int BITS          = 16,
  parameter int ADDRESS_BITS  = 4,
  parameter int MEM_ADDR_BITS = 16,
  parameter int DIV_RESET     = 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [ADDRESS_BITS-1:0]  ADDRESS,
  input  logic [BITS-1:0]          DATA_IN,
  output logic [BITS-1:0]          DATA_OUT,
  input  logic                     WR,
  output logic                     MOSI,
  input  logic                     MISO,
  output logic                     SCK,
  output logic                     CSb,
  output logic                     wvalid,
  input  logic                     wready,
  output logic [MEM_ADDR_BITS-1:0] memory_address,
  output logic [15:0]              memory_data,
  output logic                     irq
);
  state_e state_q, state_d;
  op_e    op_q, op_d, cmd_op;
  logic [15:0] addr_lo_q, addr_lo_d, wdata_q, wdata_d;
  logic [7:0]  addr_hi_q, addr_hi_d;
  logic [BITS-1:0] data_q, data_d;
  logic [MEM_ADDR_BITS-1:0] dma_addr_q, dma_addr_d, dma_count_q, dma_count_d;
  logic [MEM_ADDR_BITS-1:0] waddr_q, waddr_d, wcount_q, wcount_d;
  logic [3:0]  div_q, div_d, wdiv_q, wdiv_d;
  logic done_q, done_d, aborted_q, aborted_d, abort_q, abort_d;
  logic fast_q, fast_d, irq_en_q, irq_en_d;
  logic busy, cmd_go, abort_now;
  logic eng_start, eng_stop, eng_mosi_en, eng_done, eng_sck;
  logic [4:0]  eng_nbits;
  logic [23:0] eng_tx;
  logic [15:0] eng_rx;

  assign busy      = (state_q != S_IDLE);
  assign cmd_go    = WR && (ADDRESS == ADDRESS_BITS'(REG_CMD)) && !busy
                     && (|DATA_IN[CMD_SLEEP:CMD_READ]);
  // Aborts land only while SCK is low so the bus is never left mid-pulse.
  assign abort_now = abort_q && !eng_sck;

  always_comb begin
    if (DATA_IN[CMD_READ])      cmd_op = fast_q ? OP_FAST : OP_READ;
    else if (DATA_IN[CMD_WAKE]) cmd_op = OP_WAKE;
    else                        cmd_op = OP_SLEEP;
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cmd_go) state_d = S_CMD;
      S_CMD:    if (abort_now) state_d = S_DONE;
                else if (eng_done) state_d = (op_q == OP_WAKE || op_q == OP_SLEEP) ? S_DONE : S_ADDR;
      S_ADDR:   if (abort_now) state_d = S_DONE;
                else if (eng_done) state_d = (op_q == OP_FAST) ? S_DUMMY : S_DATA;
      S_DUMMY:  if (abort_now) state_d = S_DONE;
                else if (eng_done) state_d = S_DATA;
      S_DATA:   if (abort_now) state_d = S_DONE;
                else if (eng_done) state_d = S_MEM_WR;
      S_MEM_WR: if (wready) state_d = (abort_q || wcount_q == '0) ? S_DONE : S_DATA;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    eng_start   = 1'b0;
    eng_stop    = 1'b0;
    eng_mosi_en = 1'b0;
    eng_nbits   = 5'd16;
    eng_tx      = 24'd0;
    case (state_q)
      S_IDLE: if (cmd_go) begin
        eng_start   = 1'b1;
        eng_mosi_en = 1'b1;
        eng_nbits   = 5'd8;
        eng_tx      = {opcode(cmd_op), 16'h0};
      end
      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        eng_stop = abort_now;
        if (!abort_now && eng_done && state_d != S_MEM_WR && state_d != S_DONE) begin
          eng_start = 1'b1;
          if (state_q == S_CMD) begin
            eng_mosi_en = 1'b1;
            eng_nbits   = 5'd24;
            eng_tx      = {addr_hi_q, addr_lo_q};
          end else if (state_d == S_DUMMY) begin
            eng_nbits = 5'd8;
          end
        end
      end
      S_MEM_WR: eng_start = (state_d == S_DATA);
      default: ;
    endcase
    CSb            = (state_q == S_IDLE) || (state_q == S_DONE);
    wvalid         = (state_q == S_MEM_WR);
    irq            = (state_q == S_DONE) && irq_en_q;
    memory_address = waddr_q;
    memory_data    = wdata_q;
  end

  always_comb begin
    addr_lo_d = addr_lo_q;  addr_hi_d = addr_hi_q;  data_d = data_q;
    dma_addr_d = dma_addr_q;  dma_count_d = dma_count_q;
    fast_d = fast_q;  irq_en_d = irq_en_q;  div_d = div_q;
    op_d = op_q;  waddr_d = waddr_q;  wcount_d = wcount_q;  wdiv_d = wdiv_q;
    wdata_d = wdata_q;  done_d = done_q;  aborted_d = aborted_q;  abort_d = abort_q;
    if (WR) begin
      case (ADDRESS)
        ADDRESS_BITS'(REG_ADDR_LO):   addr_lo_d   = DATA_IN[15:0];
        ADDRESS_BITS'(REG_ADDR_HI):   addr_hi_d   = DATA_IN[7:0];
        ADDRESS_BITS'(REG_DMA_ADDR):  dma_addr_d  = DATA_IN[MEM_ADDR_BITS-1:0];
        ADDRESS_BITS'(REG_DMA_COUNT): dma_count_d = DATA_IN[MEM_ADDR_BITS-1:0];
        ADDRESS_BITS'(REG_CTRL): begin
          fast_d   = DATA_IN[CTRL_FAST];
          irq_en_d = DATA_IN[CTRL_IRQ_EN];
          div_d    = DATA_IN[CTRL_DIV_LSB +: 4];
        end
        ADDRESS_BITS'(REG_CMD): if (busy && DATA_IN[CMD_ABORT]) abort_d = 1'b1;
        default: ;
      endcase
    end
    if (cmd_go) begin
      op_d = cmd_op;  waddr_d = dma_addr_q;  wcount_d = dma_count_q;  wdiv_d = div_q;
      done_d = 1'b0;  aborted_d = 1'b0;  abort_d = 1'b0;
    end
    // First flash byte goes to the low half of the memory word.
    if (state_q == S_DATA && eng_done) wdata_d = {eng_rx[7:0], eng_rx[15:8]};
    if (state_q == S_MEM_WR && wready) begin
      waddr_d = waddr_q + 1'b1;
      data_d  = BITS'(wdata_q);
      if (wcount_q != '0) wcount_d = wcount_q - 1'b1;
    end
    if (abort_q && state_q != S_DONE && state_d == S_DONE) aborted_d = 1'b1;
    if (state_q == S_DONE) begin
      done_d  = 1'b1;
      abort_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_lo_q <= '0;  addr_hi_q <= '0;  data_q <= '0;  dma_addr_q <= '0;  dma_count_q <= '0;
      fast_q <= 1'b0;  irq_en_q <= 1'b0;  div_q <= 4'(DIV_RESET);  op_q <= OP_READ;
      waddr_q <= '0;  wcount_q <= '0;  wdiv_q <= 4'(DIV_RESET);  wdata_q <= '0;
      done_q <= 1'b0;  aborted_q <= 1'b0;  abort_q <= 1'b0;
    end else begin
      addr_lo_q <= addr_lo_d;  addr_hi_q <= addr_hi_d;  data_q <= data_d;
      dma_addr_q <= dma_addr_d;  dma_count_q <= dma_count_d;
      fast_q <= fast_d;  irq_en_q <= irq_en_d;  div_q <= div_d;  op_q <= op_d;
      waddr_q <= waddr_d;  wcount_q <= wcount_d;  wdiv_q <= wdiv_d;  wdata_q <= wdata_d;
      done_q <= done_d;  aborted_q <= aborted_d;  abort_q <= abort_d;
    end
  end

  always_comb begin
    DATA_OUT = '0;
    case (ADDRESS)
      ADDRESS_BITS'(REG_ADDR_LO):   DATA_OUT = BITS'(addr_lo_q);
      ADDRESS_BITS'(REG_ADDR_HI):   DATA_OUT = BITS'(addr_hi_q);
      ADDRESS_BITS'(REG_DATA):      DATA_OUT = data_q;
      ADDRESS_BITS'(REG_STATUS):    DATA_OUT = BITS'({aborted_q, busy, done_q});
      ADDRESS_BITS'(REG_DMA_ADDR):  DATA_OUT = BITS'(dma_addr_q);
      ADDRESS_BITS'(REG_DMA_COUNT): DATA_OUT = BITS'(dma_count_q);
      ADDRESS_BITS'(REG_CTRL):      DATA_OUT = BITS'({div_q, 2'b00, irq_en_q, fast_q});
      default: ;
    endcase
  end

  spi_shift_engine u_eng (
    .clk     (CLK),
    .rst     (RST),
    .start   (eng_start),
    .stop    (eng_stop),
    .mosi_en (eng_mosi_en),
    .div     (wdiv_q),
    .nbits   (eng_nbits),
    .tx_data (eng_tx),
    .miso    (MISO),
    .sck     (eng_sck),
    .mosi    (MOSI),
    .done    (eng_done),
    .rx_data (eng_rx)
  );
  assign SCK = eng_sck;

endmodule

// File: tb/tb_spi_flash_dma.sv
// Directed bench for spi_flash_dma with a behavioural SPI flash and a DMA
// sink that can stall wready.
module tb_spi_flash_dma;
  logic        CLK = 1'b0;
  logic        RST, WR, MISO, SCK, MOSI, CSb, wvalid, irq;
  logic        wready = 1'b0;
  logic [3:0]  ADDRESS;
  logic [15:0] DATA_IN, DATA_OUT, memory_address, memory_data;

  int tests = 0, failed = 0;
  int rise_cnt = 0, base = 0, hdr = 32, stall = 0;
  int wr_n = 0, stab_err = 0, wv_hi = 0, irq_n = 0, wv_cnt = 0, mb;
  logic [15:0] wr_a [64];
  logic [15:0] wr_d [64];
  logic        mosi_bits [1024];
  logic [7:0]  byt;
  logic        prev_wv = 1'b0, prev_acc = 1'b0;
  logic [15:0] prev_a = '0, prev_d = '0;
  time         last_rise = 0, prev_rise = 0;

  spi_flash_dma #(.BITS(16), .ADDRESS_BITS(4), .MEM_ADDR_BITS(16), .DIV_RESET(3)) dut (
    .CLK(CLK), .RST(RST), .ADDRESS(ADDRESS), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
    .WR(WR), .MOSI(MOSI), .MISO(MISO), .SCK(SCK), .CSb(CSb), .wvalid(wvalid),
    .wready(wready), .memory_address(memory_address), .memory_data(memory_data), .irq(irq)
  );

  always #5 CLK = ~CLK;

  // Flash: logs MOSI on each SCK rise; after hdr bits it streams 0x11,0x22,...
  always @(posedge SCK) begin
    mosi_bits[rise_cnt % 1024] = MOSI;
    prev_rise = last_rise;
    last_rise = $time;
    rise_cnt++;
  end

  always_comb begin
    mb   = rise_cnt - base - hdr;
    byt  = 8'h00;
    MISO = 1'b0;
    if (mb >= 0 && mb < 256) begin
      byt  = 8'((((mb / 8) + 1) % 16) * 17);
      MISO = byt[7 - (mb % 8)];
    end
  end

  // DMA sink: holds wready low for 'stall' wvalid cycles per word.
  always @(negedge CLK) begin
    wready = wvalid && (wv_cnt >= stall);
    if (wvalid) begin
      if (prev_wv && !prev_acc && (memory_address !== prev_a || memory_data !== prev_d)) stab_err++;
      wv_hi++;
      if (wready) begin
        wr_a[wr_n % 64] = memory_address;
        wr_d[wr_n % 64] = memory_data;
        wr_n++;
      end
    end
    if (irq) irq_n++;
    prev_wv  = wvalid;
    prev_acc = wvalid && wready;
    prev_a   = memory_address;
    prev_d   = memory_data;
    wv_cnt   = wvalid ? wv_cnt + 1 : 0;
  end

  function automatic logic [63:0] get_bits(input int from, input int n);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++) r = {r[62:0], mosi_bits[(from + i) % 1024]};
    return r;
  endfunction

  task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
    @(negedge CLK);
    ADDRESS = a; DATA_IN = d; WR = 1'b1;
    @(negedge CLK);
    WR = 1'b0;
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [15:0] v);
    ADDRESS = a;
    #1 v = DATA_OUT;
  endtask

  task automatic wait_idle(input string name);
    logic [15:0] s;
    bit ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge CLK);
      rd_reg(4'd4, s);
      ok = !s[1];
    end
    tests++;
    if (!ok) begin failed++; $display("FAIL %s_timeout: busy still set after 5000 cycles", name); end
  endtask

  task automatic setup(input logic [15:0] ctrl, input logic [15:0] da, input logic [15:0] cnt, input int h);
    wr_reg(4'd7, ctrl);
    wr_reg(4'd0, 16'h2345);
    wr_reg(4'd1, 16'h0001);
    wr_reg(4'd5, da);
    wr_reg(4'd6, cnt);
    hdr  = h;
    base = rise_cnt;
  endtask

  task automatic test_reset;
    logic [15:0] v;
    RST = 1'b1; WR = 1'b0; ADDRESS = '0; DATA_IN = '0;
    repeat (3) @(negedge CLK);
    tests++; if ({CSb, SCK, MOSI, wvalid, irq} !== 5'b10000) begin failed++;
      $display("FAIL reset_pins: got %b want 10000", {CSb, SCK, MOSI, wvalid, irq}); end
    rd_reg(4'd7, v);
    tests++; if (v !== 16'h0030) begin failed++; $display("FAIL reset_ctrl: got %h want 0030", v); end
    rd_reg(4'd4, v);
    tests++; if (v !== 16'h0000) begin failed++; $display("FAIL reset_status: got %h want 0000", v); end
    RST = 1'b0;
  endtask

  task automatic test_read;
    logic [15:0] v;
    int w0 = wr_n, i0 = irq_n;
    stall = 0;
    setup(16'h0002, 16'h0100, 16'h0001, 32);
    wr_reg(4'd2, 16'h0001);
    tests++; if ({CSb, SCK} !== 2'b00) begin failed++;
      $display("FAIL read_csb_fall: got %b want 00", {CSb, SCK}); end
    @(negedge CLK);
    tests++; if (SCK !== 1'b1) begin failed++; $display("FAIL read_first_rise: got %b want 1", SCK); end
    wait_idle("read");
    tests++; if (get_bits(base, 32) !== 64'h0301_2345) begin failed++;
      $display("FAIL read_mosi: got %h want 03012345", get_bits(base, 32)); end
    tests++; if (wr_n - w0 !== 2) begin failed++; $display("FAIL read_nwr: got %0d want 2", wr_n - w0); end
    tests++; if ({wr_a[w0 % 64], wr_d[w0 % 64], wr_a[(w0 + 1) % 64], wr_d[(w0 + 1) % 64]} !== 64'h0100_2211_0101_4433) begin
      failed++; $display("FAIL read_words: got %h %h %h %h want 0100 2211 0101 4433",
        wr_a[w0 % 64], wr_d[w0 % 64], wr_a[(w0 + 1) % 64], wr_d[(w0 + 1) % 64]); end
    tests++; if (irq_n - i0 !== 1) begin failed++; $display("FAIL read_irq: got %0d want 1", irq_n - i0); end
    rd_reg(4'd4, v);
    tests++; if (v !== 16'h0001) begin failed++; $display("FAIL read_status: got %h want 0001", v); end
    rd_reg(4'd3, v);
    tests++; if (v !== 16'h4433) begin failed++; $display("FAIL read_data_reg: got %h want 4433", v); end
    rd_reg(4'd15, v);
    tests++; if (v !== 16'h0000) begin failed++; $display("FAIL read_unused: got %h want 0000", v); end
  endtask

  task automatic test_fast;
    int w0 = wr_n;
    setup(16'h0033, 16'h0100, 16'h0001, 40);
    wr_reg(4'd2, 16'h0001);
    wait_idle("fast");
    tests++; if (get_bits(base, 40) !== 64'h0B_0123_4500) begin failed++;
      $display("FAIL fast_mosi: got %h want 0b01234500", get_bits(base, 40)); end
    tests++; if (last_rise - prev_rise !== 80) begin failed++;
      $display("FAIL fast_period: got %0t want 80", last_rise - prev_rise); end
    tests++; if ({wr_d[w0 % 64], wr_d[(w0 + 1) % 64]} !== 32'h2211_4433 || wr_n - w0 !== 2) begin failed++;
      $display("FAIL fast_words: got %h %h n=%0d want 2211 4433 n=2", wr_d[w0 % 64], wr_d[(w0 + 1) % 64], wr_n - w0); end
  endtask

  task automatic test_stall;
    int w0 = wr_n, h0 = wv_hi, e0 = stab_err;
    setup(16'h0002, 16'h0200, 16'h0002, 32);
    stall = 5;
    wr_reg(4'd2, 16'h0001);
    wait_idle("stall");
    stall = 0;
    tests++; if (wr_n - w0 !== 3) begin failed++; $display("FAIL stall_nwr: got %0d want 3", wr_n - w0); end
    tests++; if ({wr_a[(w0 + 2) % 64], wr_d[(w0 + 2) % 64]} !== 32'h0202_6655) begin failed++;
      $display("FAIL stall_word2: got %h %h want 0202 6655", wr_a[(w0 + 2) % 64], wr_d[(w0 + 2) % 64]); end
    tests++; if (wv_hi - h0 !== 18) begin failed++; $display("FAIL stall_wvalid_cycles: got %0d want 18", wv_hi - h0); end
    tests++; if (stab_err - e0 !== 0) begin failed++; $display("FAIL stall_stable: got %0d changes want 0", stab_err - e0); end
  endtask

  task automatic test_abort;
    logic [15:0] v;
    int w0 = wr_n, n = 0;
    setup(16'h0002, 16'h0300, 16'h0003, 32);
    wr_reg(4'd2, 16'h0001);
    while (wr_n - w0 < 2 && n < 2000) begin @(negedge CLK); n++; end
    tests++; if (wr_n - w0 < 2) begin failed++; $display("FAIL abort_wait: got %0d writes want 2", wr_n - w0); end
    repeat (4) @(negedge CLK);
    wr_reg(4'd2, 16'h0008);
    wait_idle("abort");
    repeat (40) @(negedge CLK);
    tests++; if (wr_n - w0 !== 2) begin failed++; $display("FAIL abort_nwr: got %0d want 2", wr_n - w0); end
    tests++; if (CSb !== 1'b1) begin failed++; $display("FAIL abort_csb: got %b want 1", CSb); end
    rd_reg(4'd4, v);
    tests++; if (v !== 16'h0005) begin failed++; $display("FAIL abort_status: got %h want 0005", v); end
  endtask

  task automatic test_wake_sleep;
    int w0 = wr_n, i0 = irq_n;
    setup(16'h0000, 16'h0000, 16'h0000, 32);
    wr_reg(4'd2, 16'h0006);
    wr_reg(4'd2, 16'h0001);
    wait_idle("wake");
    tests++; if (rise_cnt - base !== 8 || get_bits(base, 8) !== 64'hAB) begin failed++;
      $display("FAIL wake: got %0d clocks byte %h want 8 clocks byte ab", rise_cnt - base, get_bits(base, 8)); end
    base = rise_cnt;
    wr_reg(4'd2, 16'h0004);
    wait_idle("sleep");
    tests++; if (rise_cnt - base !== 8 || get_bits(base, 8) !== 64'hB9) begin failed++;
      $display("FAIL sleep: got %0d clocks byte %h want 8 clocks byte b9", rise_cnt - base, get_bits(base, 8)); end
    tests++; if (wr_n - w0 !== 0 || irq_n - i0 !== 0) begin failed++;
      $display("FAIL wake_sleep_side: got %0d writes %0d irq want 0 0", wr_n - w0, irq_n - i0); end
  endtask

  task automatic test_wrap;
    int w0 = wr_n;
    setup(16'h0000, 16'hFFFF, 16'h0001, 32);
    wr_reg(4'd2, 16'h0001);
    wait_idle("wrap");
    tests++; if ({wr_a[w0 % 64], wr_a[(w0 + 1) % 64]} !== 32'hFFFF_0000 || wr_n - w0 !== 2) begin failed++;
      $display("FAIL wrap_addr: got %h %h want ffff 0000", wr_a[w0 % 64], wr_a[(w0 + 1) % 64]); end
  endtask

  task automatic test_rst_mid;
    logic [15:0] v;
    int n = 0;
    setup(16'h0002, 16'h0400, 16'h0001, 32);
    wr_reg(4'd2, 16'h0001);
    while (rise_cnt - base < 12 && n < 500) begin @(negedge CLK); n++; end
    tests++; if (rise_cnt - base < 12) begin failed++; $display("FAIL rst_wait: got %0d clocks want 12", rise_cnt - base); end
    RST = 1'b1;
    @(negedge CLK);
    tests++; if ({CSb, SCK, wvalid} !== 3'b100) begin failed++;
      $display("FAIL rst_mid_pins: got %b want 100", {CSb, SCK, wvalid}); end
    rd_reg(4'd4, v);
    tests++; if (v !== 16'h0000) begin failed++; $display("FAIL rst_mid_status: got %h want 0000", v); end
    rd_reg(4'd7, v);
    tests++; if (v !== 16'h0030) begin failed++; $display("FAIL rst_mid_ctrl: got %h want 0030", v); end
    RST = 1'b0;
  endtask

  initial begin
    test_reset;
    test_read;
    test_fast;
    test_stall;
    test_abort;
    test_wake_sleep;
    test_wrap;
    test_rst_mid;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
